// File: rtl/fsm_share_arbiter_if.sv
// Bundle between the requester agents, the shared Moore machine and the arbiter.
// Handshake: a symbol moves on a rising clk edge where reqN_valid and reqN_ready are both high; responses are valid-only, no backpressure.
interface fsm_share_arbiter_if;
    logic       req0_valid;
    logic       req1_valid;
    logic       req0_ready;
    logic       req1_ready;
    logic [1:0] req0_sym;
    logic [1:0] req1_sym;
    logic       req0_last;
    logic       req1_last;
    logic       fsm_i;
    logic       fsm_j;
    logic       fsm_x;
    logic       fsm_y;
    logic       rsp_valid;
    logic       rsp_id;
    logic [1:0] rsp_xy;
    logic       rsp_last;
    logic       busy;
    logic       abort;
    logic [1:0] dbg_state;

    modport master (
        output req0_valid, req1_valid, req0_sym, req1_sym, req0_last, req1_last,
        output fsm_x, fsm_y,
        input  req0_ready, req1_ready, fsm_i, fsm_j,
        input  rsp_valid, rsp_id, rsp_xy, rsp_last, busy, abort, dbg_state
    );

    modport slave (
        input  req0_valid, req1_valid, req0_sym, req1_sym, req0_last, req1_last,
        input  fsm_x, fsm_y,
        output req0_ready, req1_ready, fsm_i, fsm_j,
        output rsp_valid, rsp_id, rsp_xy, rsp_last, busy, abort, dbg_state
    );
endinterface

// File: rtl/fsm_share_arbiter.sv
// Round-robin owner of one shared i/j -> x/y Moore machine: homes it to A,
// streams the owner's symbols into it and returns {x,y} three cycles after each accept.
module fsm_share_arbiter #(
    parameter int TIMEOUT = 16
) (
    input logic               clk,
    input logic               rstN,
    fsm_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOME = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [7:0] LP_LAST_BUBBLE = 8'(TIMEOUT - 1);

    state_t     r_state;
    logic       r_ptr;
    logic       r_owner;
    logic [1:0] r_ready;
    logic       r_home_step;
    logic [7:0] r_bubble;
    logic [1:0] r_home_cnt;
    logic       r_fsm_i;
    logic       r_fsm_j;
    logic       r_busy;
    logic       r_abort;
    logic       r_p1_vld, r_p1_id, r_p1_last;
    logic       r_p2_vld, r_p2_id, r_p2_last;
    logic       r_rsp_vld, r_rsp_id, r_rsp_last;
    logic [1:0] r_rsp_xy;

    logic       w_acc;
    logic [1:0] w_sym;
    logic       w_last;
    logic       w_pick;
    logic       w_homed;

    assign w_acc  = (r_ready[0] & bus.req0_valid) | (r_ready[1] & bus.req1_valid);
    assign w_sym  = r_owner ? bus.req1_sym  : bus.req0_sym;
    assign w_last = r_owner ? bus.req1_last : bus.req0_last;
    assign w_pick = (bus.req0_valid & bus.req1_valid) ? r_ptr : bus.req1_valid;
    // The drive of the grant cycle still steps the machine, so it must be {0,0} too.
    assign w_homed = (r_home_cnt == 2'd2) && !r_fsm_i && !r_fsm_j;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 1'b0;
            r_owner     <= 1'b0;
            r_ready     <= 2'b00;
            r_home_step <= 1'b0;
            r_bubble    <= 8'd0;
            r_home_cnt  <= 2'd2;
            r_fsm_i     <= 1'b0;
            r_fsm_j     <= 1'b0;
            r_busy      <= 1'b0;
            r_abort     <= 1'b0;
            r_p1_vld    <= 1'b0;
            r_p1_id     <= 1'b0;
            r_p1_last   <= 1'b0;
            r_p2_vld    <= 1'b0;
            r_p2_id     <= 1'b0;
            r_p2_last   <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_xy    <= 2'b00;
        end else begin
            r_abort <= 1'b0;
            r_fsm_i <= w_acc & w_sym[1];
            r_fsm_j <= w_acc & w_sym[0];

            if (r_fsm_i || r_fsm_j) begin
                r_home_cnt <= 2'd0;
            end else if (r_home_cnt != 2'd2) begin
                r_home_cnt <= r_home_cnt + 2'd1;
            end

            // Accept -> drive (n+1) -> machine output (n+2) -> response (n+3).
            r_p1_vld   <= w_acc;
            r_p1_id    <= w_acc & r_owner;
            r_p1_last  <= w_acc & w_last;
            r_p2_vld   <= r_p1_vld;
            r_p2_id    <= r_p1_id;
            r_p2_last  <= r_p1_last;
            r_rsp_vld  <= r_p2_vld;
            r_rsp_id   <= r_p2_id;
            r_rsp_last <= r_p2_last;
            r_rsp_xy   <= r_p2_vld ? {bus.fsm_x, bus.fsm_y} : 2'b00;

            case (r_state)
                ST_IDLE: begin
                    if (bus.req0_valid || bus.req1_valid) begin
                        r_owner  <= w_pick;
                        r_ptr    <= ~w_pick;
                        r_busy   <= 1'b1;
                        r_bubble <= 8'd0;
                        if (w_homed) begin
                            r_state <= ST_RUN;
                            r_ready <= w_pick ? 2'b10 : 2'b01;
                        end else begin
                            r_state     <= ST_HOME;
                            r_home_step <= 1'b0;
                        end
                    end
                end
                ST_HOME: begin
                    if (r_home_step) begin
                        r_state <= ST_RUN;
                        r_ready <= r_owner ? 2'b10 : 2'b01;
                    end else begin
                        r_home_step <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_acc) begin
                        r_bubble <= 8'd0;
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_ready <= 2'b00;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_bubble == LP_LAST_BUBBLE) begin
                        r_abort  <= 1'b1;
                        r_state  <= ST_IDLE;
                        r_ready  <= 2'b00;
                        r_busy   <= 1'b0;
                        r_bubble <= 8'd0;
                    end else begin
                        r_bubble <= r_bubble + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 2'b00;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req0_ready = r_ready[0];
    assign bus.req1_ready = r_ready[1];
    assign bus.fsm_i      = r_fsm_i;
    assign bus.fsm_j      = r_fsm_j;
    assign bus.rsp_valid  = r_rsp_vld;
    assign bus.rsp_id     = r_rsp_id;
    assign bus.rsp_xy     = r_rsp_xy;
    assign bus.rsp_last   = r_rsp_last;
    assign bus.busy       = r_busy;
    assign bus.abort      = r_abort;
    assign bus.dbg_state  = r_state;
endmodule

// File: tb/tb_fsm_share_arbiter.sv
// Directed bench for fsm_share_arbiter with a behavioural shared Moore machine
// (A=11, B=01, C=10, D=00 on {x,y}) and a cycle-stamped response scoreboard.
module tb_fsm_share_arbiter;
    localparam int W = 20;  // {cycle[15:0], id, last, xy}

    logic clk;
    logic rstN;
    fsm_share_arbiter_if bus ();

    fsm_share_arbiter #(.TIMEOUT(4)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] cyc;
    always @(posedge clk) cyc <= cyc + 16'd1;
    initial cyc = 16'd0;

    // ---------------- shared machine model ----------------
    logic [1:0] m_state;  // A=0 B=1 C=2 D=3

    function automatic logic [1:0] m_next(input logic [1:0] s, input logic i, input logic j);
        case ({i, j})
            2'b00:   m_next = (s == 2'd0 || s == 2'd3) ? 2'd0 : 2'd3;
            2'b10:   m_next = 2'd1;
            2'b01:   m_next = 2'd2;
            default: m_next = (s == 2'd0 || s == 2'd3) ? 2'd3 : 2'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) m_state <= 2'd0;
        else       m_state <= m_next(m_state, bus.fsm_i, bus.fsm_j);
    end

    assign bus.fsm_x = (m_state == 2'd0) || (m_state == 2'd2);
    assign bus.fsm_y = (m_state == 2'd0) || (m_state == 2'd1);

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            check("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                check("rsp_beat", {12'd0, cyc, bus.rsp_id, bus.rsp_last, bus.rsp_xy},
                      {12'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rstN = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit id, input logic [1:0] sym, input bit last,
                        input logic [1:0] xy, output int waited);
        bit seen;
        seen = 1'b0;
        waited = 0;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_sym = sym; bus.req1_last = last;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_sym = sym; bus.req0_last = last;
        end
        while (!seen && waited < 40) begin
            @(negedge clk);
            waited++;
            if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
                seen = 1'b1;
                exp_q.push_back({cyc + 16'd3, id, last, xy});
            end
        end
        check("handshake_seen", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        if (last || !seen) begin
            if (id) bus.req1_valid = 1'b0;
            else    bus.req0_valid = 1'b0;
        end
    endtask

    task automatic expect_home();
        @(negedge clk);
        check("gap_state_idle", {30'd0, bus.dbg_state}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("home_state", {30'd0, bus.dbg_state}, 32'd1);
            check("home_ready_low", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            check("home_drive_zero", {30'd0, bus.fsm_i, bus.fsm_j}, 32'd0);
        end
    endtask

    task automatic drain();
        repeat (6) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    int w;
    int n_rsp;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_sym = 2'b00; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_sym = 2'b00; bus.req1_last = 1'b0;
        rstN = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        check("rst_drive", {30'd0, bus.fsm_i, bus.fsm_j}, 32'd0);
        check("rst_rsp", {27'd0, bus.rsp_valid, bus.rsp_id, bus.rsp_xy, bus.rsp_last}, 32'd0);
        check("rst_busy_abort", {30'd0, bus.busy, bus.abort}, 32'd0);
        check("rst_state", {30'd0, bus.dbg_state}, 32'd0);
        do_reset();

        // Single transaction straight after reset: no homing, xy 01,10,01.
        send(1'b0, 2'b10, 1'b0, 2'b01, w);
        check("t1_no_home_wait", w, 32'd2);
        send(1'b0, 2'b01, 1'b0, 2'b10, w);
        check("t1_back_to_back", w, 32'd1);
        send(1'b0, 2'b10, 1'b1, 2'b01, w);
        drain();
        check("t1_busy_after", {31'd0, bus.busy}, 32'd0);

        // Contention after reset: req0 first, then req1 with two HOME cycles.
        do_reset();
        bus.req1_valid = 1'b1; bus.req1_sym = 2'b10; bus.req1_last = 1'b1;
        send(1'b0, 2'b10, 1'b1, 2'b01, w);
        check("t2_req0_first", w, 32'd2);
        expect_home();
        send(1'b1, 2'b10, 1'b1, 2'b01, w);
        check("t2_req1_after_home", w, 32'd1);
        drain();

        // Leave machine in C, then a new grant must home it before {0,0} -> A (11).
        bus.req1_valid = 1'b1; bus.req1_sym = 2'b00; bus.req1_last = 1'b1;
        send(1'b0, 2'b10, 1'b0, 2'b01, w);
        send(1'b0, 2'b01, 1'b1, 2'b10, w);
        expect_home();
        send(1'b1, 2'b00, 1'b1, 2'b11, w);
        drain();

        // Timeout: one symbol then silence; abort after 4 bubbles, response still lands.
        send(1'b1, 2'b01, 1'b0, 2'b10, w);
        bus.req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("to_abort_low", {31'd0, bus.abort}, 32'd0);
            check("to_busy_high", {31'd0, bus.busy}, 32'd1);
        end
        @(negedge clk);
        check("to_abort_pulse", {31'd0, bus.abort}, 32'd1);
        check("to_busy_low", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        check("to_abort_single", {31'd0, bus.abort}, 32'd0);
        drain();

        // Reset while a response is in flight: outputs clear at once, nothing emerges.
        send(1'b0, 2'b10, 1'b0, 2'b01, w);
        bus.req0_valid = 1'b0;
        rstN = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        check("mid_rst_drive", {30'd0, bus.fsm_i, bus.fsm_j}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_state", {30'd0, bus.dbg_state}, 32'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        n_rsp = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) n_rsp++;
        end
        check("post_rst_no_rsp", n_rsp, 32'd0);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
